// File: rtl/inst_buffer_pkg.sv
// Shared core constants for the instruction buffer: entry geometry and default depth.
// An entry is {pc, instr} and travels from fetch to decode unchanged.
package inst_buffer_pkg;

  localparam int IB_WIDTH    = 32;
  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;
  localparam int IB_DEPTH    = 8;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer_storage.sv
// Register array behind the instruction buffer: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module ib_storage
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int WIDTH = IB_WIDTH
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/inst_buffer.sv
// First-word-fall-through instruction buffer between fetch and decode.
// Status outputs come only from registered occupancy, so fetch may derive push from full.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int WIDTH = IB_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   full,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;
  logic w_wr_en;

  assign full       = (r_count == FULL_COUNT);
  assign head_valid = (r_count != '0);
  assign count      = r_count;

  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && head_valid;
  // A flushed push must not even land in storage, keeping the array consistent with the pointers.
  assign w_wr_en   = w_push_ok && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  ib_storage #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_storage (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr),
    .i_wr_data(push_data),
    .i_rd_addr(r_rd_ptr),
    .o_rd_data(head_data)
  );

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized scoreboard bench for inst_buffer: a queue-based FIFO model predicts
// status each cycle and queues expected head entries for the pop monitor.
module tb_inst_buffer;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             full;
  logic             pop;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic             flush;
  logic [3:0]       count;

  int tests;
  int failed;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] expQ[$];

  inst_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .pop       (pop),
    .head_valid(head_valid),
    .head_data (head_data),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop consumes the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && pop && !flush && head_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pop", head_data, 32'hxxxx_xxxx);
      end else begin
        checkOutput("pop_data", head_data, expQ.pop_front());
      end
    end
  end

  // Called at posedge+1; status is compared against the model before the edge it drives.
  task automatic applyStimulus(input logic p, input logic [31:0] d, input logic q, input logic f);
    bit pushOk;
    bit popOk;
    push = p; push_data = d; pop = q; flush = f;
    #1;
    checkOutput("count", 32'(count), 32'(model.size()));
    checkOutput("full", 32'(full), 32'(model.size() == DEPTH));
    checkOutput("head_valid", 32'(head_valid), 32'(model.size() != 0));
    if (model.size() != 0) checkOutput("head_data", head_data, model[0]);
    pushOk = p && (model.size() < DEPTH);
    popOk  = q && (model.size() > 0);
    if (f) begin
      model.delete();
    end else begin
      if (popOk) expQ.push_back(model.pop_front());
      if (pushOk) model.push_back(d);
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic midReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_head_valid", 32'(head_valid), 32'd0);
    model.delete();
    push = 1'b1; push_data = 32'hDEAD_0001; pop = 1'b1; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_head_valid", 32'(head_valid), 32'd0);
    checkOutput("reset_full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty pop, then a push that appears on the head one cycle later.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0010_1234, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill with a ninth push dropped, then drain in order.
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, {16'(i), 16'hA000 + 16'(i)}, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Steady state at count=3 with simultaneous push and pop.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, $urandom, 1'b1, 1'b0);

    // Full with pop: push dropped, pop accepted.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00FF_0000, 1'b1, 1'b0);

    // Flush at count=5 beats push and pop.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h1111_2222, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0020_BEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with four entries held.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    midReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 60), $urandom,
                    ($urandom_range(0, 99) < 50), ($urandom_range(0, 31) == 0));
    end

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
